// File: rtl/lab8_top.sv
// Simple RISC Machine top: multicycle 16-bit CPU, 256x16 RAM and board I/O.
// Switches are memory-mapped at 0x140 (read) and the LEDs at 0x100 (write).
package lab8_pkg;
    typedef enum logic [19:0] {
        S_RST = 20'h00001,
        S_IF1 = 20'h10000,
        S_IF2 = 20'h00002,
        S_UPC = 20'h00004,
        S_DEC = 20'h00008,
        S_EXE = 20'h00010,
        S_MEM = 20'h00020,
        S_HLT = 20'h00040
    } state_t;
endpackage

module lab8_fsm import lab8_pkg::*; (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       is_mem,
    output state_t     p,
    output logic       halted
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p      <= S_RST;
            halted <= 1'b0;
        end else begin
            case (p)
                S_RST: p <= S_IF1;
                S_IF1: p <= S_IF2;
                S_IF2: p <= S_UPC;
                S_UPC: p <= S_DEC;
                S_DEC: begin
                    if (opcode == 3'b111) begin
                        p      <= S_HLT;
                        halted <= 1'b1;
                    end else begin
                        p <= S_EXE;
                    end
                end
                S_EXE:   p <= is_mem ? S_MEM : S_IF1;
                S_MEM:   p <= S_IF1;
                S_HLT:   p <= S_HLT;
                default: p <= S_RST;
            endcase
        end
    end
endmodule

module lab8_cpu import lab8_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_rdata,
    output logic [8:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        halted,
    output logic [15:0] c
);
    logic [8:0]  PC, addr_r;
    logic [15:0] ir, shifted, diff, sx8, sx5, sum5, wb_val;
    logic [15:0] regs [0:7];
    logic [2:0]  opcode, rn, rd, rm, wb_idx;
    logic [1:0]  op, sh;
    logic        z, n, v, taken, is_mem, wb_en;
    state_t      p;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign sx8    = {{8{ir[7]}}, ir[7:0]};
    assign sx5    = {{11{ir[4]}}, ir[4:0]};
    assign sum5   = regs[rn] + sx5;
    assign diff   = regs[rn] - shifted;
    assign is_mem = (opcode == 3'b011 || opcode == 3'b100) && op == 2'b00;

    lab8_fsm FSM (.clk(clk), .rst_n(rst_n), .opcode(opcode), .is_mem(is_mem),
                  .p(p), .halted(halted));

    always_comb begin
        case (sh)
            2'b01:   shifted = {regs[rm][14:0], 1'b0};
            2'b10:   shifted = {1'b0, regs[rm][15:1]};
            2'b11:   shifted = {regs[rm][15], regs[rm][15:1]};
            default: shifted = regs[rm];
        endcase
    end

    always_comb begin
        case (rn)
            3'd0:    taken = 1'b1;
            3'd1:    taken = z;
            3'd2:    taken = ~z;
            3'd3:    taken = n ^ v;
            3'd4:    taken = z | (n ^ v);
            default: taken = 1'b0;
        endcase
    end

    // Single write-back port; BL/BLX write the already-incremented PC into R7.
    always_comb begin
        wb_en  = 1'b0;
        wb_idx = rd;
        wb_val = shifted;
        if (p == S_EXE) begin
            case ({opcode, op})
                5'b11010: begin wb_en = 1'b1; wb_idx = rn; wb_val = sx8; end
                5'b11000: wb_en = 1'b1;
                5'b10100: begin wb_en = 1'b1; wb_val = regs[rn] + shifted; end
                5'b10110: begin wb_en = 1'b1; wb_val = regs[rn] & shifted; end
                5'b10111: begin wb_en = 1'b1; wb_val = ~shifted; end
                5'b01011, 5'b01010: begin
                    wb_en = 1'b1; wb_idx = 3'd7; wb_val = {7'd0, PC};
                end
                default: wb_en = 1'b0;
            endcase
        end else if (p == S_MEM && opcode == 3'b011) begin
            wb_en  = 1'b1;
            wb_val = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC <= 9'd0;
        end else if (p == S_UPC) begin
            PC <= PC + 9'd1;
        end else if (p == S_EXE) begin
            if (opcode == 3'b001) begin
                if (taken) PC <= PC + sx8[8:0];
            end else if ({opcode, op} == 5'b01011) begin
                PC <= PC + sx8[8:0];
            end else if ({opcode, op} == 5'b01000 || {opcode, op} == 5'b01010) begin
                PC <= regs[rd][8:0];
            end
        end
    end

    // Datapath state is not reset; reset only parks the FSM so no write fires.
    always_ff @(posedge clk) begin
        if (p == S_IF2) ir <= mem_rdata;
        if (wb_en) begin
            regs[wb_idx] <= wb_val;
            c            <= wb_val;
        end
        if (p == S_EXE) begin
            addr_r <= sum5[8:0];
            if ({opcode, op} == 5'b10101) begin
                z <= (diff == 16'd0);
                n <= diff[15];
                v <= (regs[rn][15] != shifted[15]) && (diff[15] != regs[rn][15]);
            end
        end
    end

    assign mem_addr  = (p == S_MEM) ? addr_r : PC;
    assign mem_wdata = regs[rd];
    assign mem_we    = (p == S_MEM) && (opcode == 3'b100);
endmodule

module lab8_ram (
    input  logic        clk,
    input  logic        we,
    input  logic [7:0]  addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata
);
    logic [15:0] mem [0:255];

    always @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

module lab8_top #(
    parameter string MEM_INIT_FILE = "data.txt"
) (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
);
    localparam string unused_init_file = MEM_INIT_FILE;

    logic [15:0] mem_rdata, mem_wdata, ram_q, c;
    logic [8:0]  mem_addr;
    logic [7:0]  leds;
    logic        mem_we, halted, unused_in;

    assign unused_in = &{1'b0, KEY[0], KEY[3:2], SW[9:8]};

    lab8_cpu CPU (.clk(CLOCK_50), .rst_n(KEY[1]), .mem_rdata(mem_rdata), .mem_addr(mem_addr),
                  .mem_wdata(mem_wdata), .mem_we(mem_we), .halted(halted), .c(c));

    lab8_ram MEM (.clk(CLOCK_50), .we(mem_we & ~mem_addr[8]), .addr(mem_addr[7:0]),
                  .wdata(mem_wdata), .rdata(ram_q));

    assign mem_rdata = !mem_addr[8]           ? ram_q :
                       (mem_addr == 9'h140)   ? {8'h00, SW[7:0]} : 16'h0000;

    always_ff @(posedge CLOCK_50 or negedge KEY[1]) begin
        if (!KEY[1])                           leds <= 8'h00;
        else if (mem_we && mem_addr == 9'h100) leds <= mem_wdata[7:0];
    end

    assign LEDR = {1'b0, halted, leds};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign HEX0 = seg7(c[3:0]);
    assign HEX1 = seg7(c[7:4]);
    assign HEX2 = seg7(c[11:8]);
    assign HEX3 = seg7(c[15:12]);
    assign HEX4 = 7'b1111111;
    assign HEX5 = 7'b1111111;
endmodule

// File: tb/tb_lab8_top.sv
// Bench for lab8_top: an instruction-level model of the ISA tracks each fetch,
// and directed programs pin the model with hand-computed results.
module tb_lab8_top;
    logic       clk = 1'b0;
    logic [3:0] key = 4'hF;
    logic [9:0] sw  = 10'h000;
    logic [9:0] ledr;
    logic [6:0] h0, h1, h2, h3, h4, h5;

    lab8_top dut (.CLOCK_50(clk), .KEY(key), .SW(sw), .LEDR(ledr),
                  .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3), .HEX4(h4), .HEX5(h5));

    always #5 clk = ~clk;

    localparam logic [19:0] IF1 = 20'h10000;

    int nchk = 0, nfail = 0;
    logic [15:0] mm [0:255];
    logic [15:0] mr [0:7];
    logic [7:0]  mdef = 8'h00, mleds = 8'h00;
    logic [8:0]  mpc = 9'd0;
    logic        mz = 1'b0, mn = 1'b0, mv = 1'b0, m_halted = 1'b0;
    logic        active = 1'b0, seen_halt = 1'b0, extra_seen = 1'b0;
    int          trace[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mread(input logic [8:0] a);
        if (!a[8])         return mm[a[7:0]];
        else if (a == 9'h140) return {8'h00, sw[7:0]};
        else               return 16'h0000;
    endfunction

    function automatic logic [15:0] shf(input logic [15:0] x, input logic [1:0] s);
        case (s)
            2'd1:    return x << 1;
            2'd2:    return x >> 1;
            2'd3:    return 16'($signed(x) >>> 1);
            default: return x;
        endcase
    endfunction

    task automatic mwr(input logic [2:0] i, input logic [15:0] d);
        mr[i] = d;
        mdef[i] = 1'b1;
    endtask

    // One whole instruction, as the programmer sees it.
    task automatic mstep();
        logic [15:0] ins, a, b, s8, s5, d;
        logic [2:0]  rn, rd;
        logic [8:0]  t;
        logic        tk;
        int          sd;
        ins = mread(mpc);
        rn = ins[10:8];
        rd = ins[7:5];
        a  = mr[rn];
        b  = shf(mr[ins[2:0]], ins[4:3]);
        s8 = {{8{ins[7]}}, ins[7:0]};
        s5 = {{11{ins[4]}}, ins[4:0]};
        mpc = mpc + 9'd1;
        case (ins[15:11])
            5'b11010: mwr(rn, s8);
            5'b11000: mwr(rd, b);
            5'b10100: mwr(rd, a + b);
            5'b10110: mwr(rd, a & b);
            5'b10111: mwr(rd, ~b);
            5'b10101: begin
                sd = $signed(a) - $signed(b);
                d  = a - b;
                mz = (d == 16'd0);
                mn = d[15];
                mv = (sd > 32767) || (sd < -32768);
            end
            5'b01100: begin d = a + s5; mwr(rd, mread(d[8:0])); end
            5'b10000: begin
                d = a + s5;
                if (!d[8])               mm[d[7:0]] = mr[rd];
                else if (d[8:0] == 9'h100) mleds = mr[rd][7:0];
            end
            5'b01011: begin mwr(3'd7, {7'd0, mpc}); mpc = mpc + s8[8:0]; end
            5'b01000: mpc = mr[rd][8:0];
            5'b01010: begin t = mr[rd][8:0]; mwr(3'd7, {7'd0, mpc}); mpc = t; end
            default: begin
                if (ins[15:13] == 3'b001) begin
                    case (rn)
                        3'd0:    tk = 1'b1;
                        3'd1:    tk = mz;
                        3'd2:    tk = !mz;
                        3'd3:    tk = (mn != mv);
                        3'd4:    tk = mz || (mn != mv);
                        default: tk = 1'b0;
                    endcase
                    if (tk) mpc = mpc + s8[8:0];
                end else if (ins[15:13] == 3'b111) begin
                    m_halted = 1'b1;
                end
            end
        endcase
    endtask

    function automatic int mem_diffs();
        int cnt = 0;
        for (int i = 0; i < 256; i++)
            if (dut.MEM.mem[i] !== mm[i]) cnt++;
        return cnt;
    endfunction

    always @(negedge clk) begin
        if (active) begin
            if (dut.CPU.FSM.p == IF1) begin
                if (!m_halted) begin
                    chk("fetch_pc", 32'(dut.CPU.PC), 32'(mpc));
                    chk("fetch_leds", 32'(ledr[7:0]), 32'(mleds));
                    chk("fetch_halt_led", 32'(ledr[8]), 32'd0);
                    trace.push_back(int'(dut.CPU.PC));
                    mstep();
                end else if (!extra_seen) begin
                    extra_seen = 1'b1;
                    chk("fetch_after_halt", 32'd1, 32'd0);
                end
            end
            if (ledr[8] && !seen_halt) begin
                seen_halt = 1'b1;
                chk("halt_expected", 32'(m_halted), 32'd1);
                chk("halt_pc", 32'(dut.CPU.PC), 32'(mpc));
                chk("halt_leds", 32'(ledr[7:0]), 32'(mleds));
                chk("halt_mem_diffs", 32'(mem_diffs()), 32'd0);
                for (int i = 0; i < 8; i++)
                    if (mdef[i]) chk($sformatf("halt_r%0d", i), 32'(dut.CPU.regs[i]), 32'(mr[i]));
            end
        end
    end

    task automatic put(input int a, input logic [15:0] d);
        dut.MEM.mem[a] <= d;
        mm[a] = d;
    endtask

    task automatic load(input int pid);
        for (int i = 0; i < 256; i++) put(i, 16'h0000);
        case (pid)
            1: begin
                put(0, 16'hD005); put(1, 16'hD113); put(2, 16'h5700); put(3, 16'hE000);
                put(5, 16'h8120); put(6, 16'h40E0);
            end
            2: begin
                put(0, 16'h5F02); put(1, 16'hE000); put(3, 16'hD207); put(4, 16'h40E0);
            end
            3: begin
                put(0, 16'hD300); put(1, 16'hD003); put(2, 16'hD103); put(3, 16'hA801);
                put(4, 16'h2101); put(5, 16'hD301); put(6, 16'h2201); put(7, 16'hD402);
                put(8, 16'hD002); put(9, 16'hA801); put(10, 16'h2301); put(11, 16'hD301);
                put(12, 16'h2401); put(13, 16'hD301); put(14, 16'hE000);
            end
            default: begin
                put(0, 16'hD001); put(1, 16'hD240); put(2, 16'hA00A); put(3, 16'hB860);
                put(4, 16'hD61E); put(5, 16'h6680); put(6, 16'hD5FF); put(7, 16'hB5FC);
                put(8, 16'hD614); put(9, 16'h8660); put(10, 16'h6620); put(11, 16'hC04A);
                put(12, 16'hA242); put(13, 16'h8200); put(14, 16'hD640); put(15, 16'hA2C6);
                put(16, 16'h66A0); put(17, 16'h86BF); put(18, 16'h6661); put(19, 16'hE000);
                put(30, 16'h8000);
            end
        endcase
        #1;
    endtask

    task automatic run_prog(input int pid);
        int cyc;
        bit got;
        active = 1'b0;
        @(negedge clk);
        key[1] = 1'b0;
        load(pid);
        chk("rst_state_not_if1", 32'(dut.CPU.FSM.p == IF1), 32'd0);
        chk("rst_halt_led", 32'(ledr[8]), 32'd0);
        chk("rst_leds", 32'(ledr[7:0]), 32'd0);
        @(negedge clk);
        key[1] = 1'b1;
        mpc = 9'd0; mleds = 8'h00; m_halted = 1'b0;
        seen_halt = 1'b0; extra_seen = 1'b0;
        trace.delete();
        active = 1'b1;
        got = 1'b0;
        for (cyc = 1; cyc <= 2; cyc++) begin
            @(negedge clk);
            if (dut.CPU.FSM.p == IF1) begin got = 1'b1; break; end
        end
        chk("first_if1_within_2", 32'(got), 32'd1);
        chk("first_if1_pc", 32'(dut.CPU.PC), 32'd0);
        got = 1'b0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (ledr[8]) begin got = 1'b1; break; end
        end
        chk("halt_reached", 32'(got), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int exp_tr[6];
        exp_tr = '{0, 1, 2, 5, 6, 3};

        run_prog(1);
        chk("blx_trace_len", 32'(trace.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < trace.size()) chk($sformatf("blx_trace%0d", i), 32'(trace[i]), 32'(exp_tr[i]));
        chk("blx_r7", 32'(dut.CPU.regs[7]), 32'd3);
        chk("blx_mem19", 32'(dut.MEM.mem[19]), 32'd19);
        chk("blx_halt_pc", 32'(dut.CPU.PC), 32'd4);
        chk("blx_led8", 32'(ledr[8]), 32'd1);
        chk("ledr9_zero", 32'(ledr[9]), 32'd0);
        chk("hex45_blank", 32'({h4, h5}), 32'h3FFF);

        run_prog(2);
        chk("bl_r7", 32'(dut.CPU.regs[7]), 32'd1);
        chk("bl_r2", 32'(dut.CPU.regs[2]), 32'd7);
        chk("bl_halt_pc", 32'(dut.CPU.PC), 32'd2);

        run_prog(3);
        chk("br_r3_skipped", 32'(dut.CPU.regs[3]), 32'd0);
        chk("br_r4_bne_fallthru", 32'(dut.CPU.regs[4]), 32'd2);
        chk("br_halt_pc", 32'(dut.CPU.PC), 32'd15);

        sw = 10'h35A;
        run_prog(4);
        chk("alu_add_lsl", 32'(dut.CPU.regs[0]), 32'h0081);
        chk("alu_mvn_mem20", 32'(dut.MEM.mem[20]), 32'hFF7E);
        chk("alu_ldr_rt", 32'(dut.CPU.regs[1]), 32'hFF7E);
        chk("alu_and_asr", 32'(dut.CPU.regs[7]), 32'hC000);
        chk("io_leds", 32'(ledr[7:0]), 32'h81);
        chk("io_sw", 32'(dut.CPU.regs[5]), 32'h005A);
        chk("unmapped_read", 32'(dut.CPU.regs[3]), 32'h0000);
        chk("alu_halt_pc", 32'(dut.CPU.PC), 32'd20);

        repeat (50) @(negedge clk);
        chk("hold_pc", 32'(dut.CPU.PC), 32'd20);
        chk("hold_led8", 32'(ledr[8]), 32'd1);
        chk("hold_mem", 32'(mem_diffs()), 32'd0);
        chk("hold_mem20", 32'(dut.MEM.mem[20]), 32'hFF7E);

        active = 1'b0;
        @(negedge clk);
        #2 key[1] = 1'b0;
        #1;
        chk("async_rst_led8", 32'(ledr[8]), 32'd0);
        chk("async_rst_leds", 32'(ledr[7:0]), 32'd0);
        chk("async_rst_pc", 32'(dut.CPU.PC), 32'd0);
        @(negedge clk);
        key[1] = 1'b1;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
